// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: next-PC select encodings and fetch reset constants shared with the decoder
package fetch_unit_pkg;
  typedef enum logic [1:0] {
    PC_4   = 2'd0,
    PC_J   = 2'd1,
    PC_JR  = 2'd2,
    PC_BEQ = 2'd3
  } npc_sel_e;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory bus between fetch stage and instruction memory
interface fetch_unit_if;
  logic [31:0] addr;
  logic [31:0] rdata;
  modport master(output addr, input rdata);
  modport slave(input addr, output rdata);
endinterface

// File: rtl/fetch_unit_npc.sv
// fetch_unit_npc: combinational redirect decision and target for the instruction in ID
module fetch_unit_npc
  import fetch_unit_pkg::*;
(
  input  logic [1:0]  s_npc,
  input  logic [31:0] pc4,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        valid,
  input  logic        stall,
  output logic        taken,
  output logic [31:0] target
);
  always_comb begin
    taken  = valid && !stall && (s_npc == PC_J || s_npc == PC_JR || (s_npc == PC_BEQ && rs_data == rt_data));
    target = s_npc == PC_J  ? {pc4[31:28], instr[25:0], 2'b00} :
             s_npc == PC_JR ? rs_data :
                              pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, IF/ID pipeline register and one-bubble redirect handling
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  fetch_unit_if.master imem,
  input  logic [1:0]   id_s_npc,
  input  logic [31:0]  id_rs_data,
  input  logic [31:0]  id_rt_data,
  output logic [31:0]  if_id_instr,
  output logic [31:0]  if_id_pc,
  output logic [31:0]  if_id_pc4,
  output logic         if_id_valid,
  output logic         flush,
  output logic [31:0]  redirect_cnt
);
  logic [31:0] pc;
  logic [31:0] target;
  logic        taken;
  fetch_unit_npc u_npc (
    .s_npc   (id_s_npc),
    .pc4     (if_id_pc4),
    .instr   (if_id_instr),
    .rs_data (id_rs_data),
    .rt_data (id_rt_data),
    .valid   (if_id_valid),
    .stall   (stall),
    .taken   (taken),
    .target  (target)
  );
  assign imem.addr = pc;
  assign flush     = taken;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_PC;
      if_id_instr  <= NOP_INSTR;
      if_id_pc     <= '0;
      if_id_pc4    <= '0;
      if_id_valid  <= 1'b0;
      redirect_cnt <= '0;
    end else if (!stall) begin
      if (taken) begin
        pc           <= target;
        if_id_instr  <= NOP_INSTR;
        if_id_pc     <= '0;
        if_id_pc4    <= '0;
        if_id_valid  <= 1'b0;
        redirect_cnt <= redirect_cnt + 32'd1;
      end else begin
        pc           <= pc + 32'd4;
        if_id_instr  <= imem.rdata;
        if_id_pc     <= pc;
        if_id_pc4    <= pc + 32'd4;
        if_id_valid  <= 1'b1;
      end
    end
  end
endmodule
